// File: rtl/des_pkg.sv
// DES key schedule shared definitions: permutation tables, shift
// schedules, state encoding and the C/D register bundle.
package des_pkg;

  localparam int KEY_W = 64;
  localparam int CD_W  = 28;
  localparam int SK_W  = 48;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  typedef struct packed {
    logic [CD_W-1:0] c;
    logic [CD_W-1:0] d;
  } cd_t;

  // 1-based FIPS bit numbers, bit 1 = MSB
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [CD_W-1:0] rot28(
    input logic [CD_W-1:0] x,
    input logic [1:0]      n,
    input logic            right
  );
    logic [CD_W-1:0] r;
    r = x;
    unique case ({right, n})
      3'b001:  r = {x[26:0], x[27]};
      3'b010:  r = {x[25:0], x[27:26]};
      3'b101:  r = {x[0], x[27:1]};
      3'b110:  r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: combinational 56-to-48 bit selection
// from the concatenated {C,D} halves.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] cd,
  output logic [SK_W-1:0]   sk
);

  for (genvar i = 0; i < SK_W; i++) begin : g_pc2
    assign sk[SK_W-1-i] = cd[2*CD_W-PC2_TBL[i]];
  end

endmodule

// File: rtl/des_key_sched.sv
// Iterative DES round-key generator, K1..K16 or K16..K1 order.
// Optional key byte parity check: define DES_KEY_PARITY_CHK_EN.
module des_key_sched
  import des_pkg::*;
#(
  parameter bit BACKPRESSURE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             decrypt,
  output logic             busy,
  output logic             sk_valid,
  input  logic             sk_ready,
  output logic [SK_W-1:0]  sk_out,
  output logic [3:0]       sk_round,
  output logic             done,
  output logic             parity_err
);

  state_t          state;
  cd_t             cd_q;
  cd_t             cd_base;
  cd_t             cd_nx;
  logic            dir;
  logic [55:0]     key_pc1;
  logic [3:0]      idx;
  logic [1:0]      sh;
  logic            rdir;
  logic            hs;
  logic [SK_W-1:0] sk_nx;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign key_pc1[55-i] = key[KEY_W-PC1_TBL[i]];
  end

  assign hs  = sk_valid & (BACKPRESSURE_EN ? sk_ready : 1'b1);
  assign idx = sk_round + 4'd1;

  // Load path rotates PC1(key); emit path rotates the held C/D
  always_comb begin
    cd_base = cd_q;
    rdir    = dir;
    sh      = dir ? DEC_SHIFT[idx] : ENC_SHIFT[idx];
    if (state == IDLE) begin
      cd_base = key_pc1;
      rdir    = decrypt;
      sh      = decrypt ? DEC_SHIFT[0] : ENC_SHIFT[0];
    end
    cd_nx.c = rot28(cd_base.c, sh, rdir);
    cd_nx.d = rot28(cd_base.d, sh, rdir);
  end

  des_pc2 u_pc2 (
    .cd (cd_nx),
    .sk (sk_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cd_q     <= '0;
      dir      <= 1'b0;
      busy     <= 1'b0;
      sk_valid <= 1'b0;
      sk_out   <= '0;
      sk_round <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cd_q     <= cd_nx;
            sk_out   <= sk_nx;
            sk_round <= '0;
            dir      <= decrypt;
            sk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (hs) begin
            if (sk_round == 4'd15) begin
              sk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              cd_q     <= cd_nx;
              sk_out   <= sk_nx;
              sk_round <= idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHK_EN
  logic key_even;

  always_comb begin
    key_even = 1'b0;
    for (int b = 0; b < 8; b++) begin
      key_even = key_even | ~(^key[8*b +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (state == IDLE && start) begin
      parity_err <= key_even;
    end
  end
`else
  logic unused_par;
  assign unused_par = ^key;
  assign parity_err = 1'b0;
`endif

endmodule
